// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: state encoding and default sizes
// shared by the multiplexed MAC sequencer.
package mac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    MAC,
    STORE,
    SHIFT
  } state_t;

  localparam int TAPS_DEF = 16;
  localparam int N_CH_DEF = 2;
  localparam int CNT_W    = 5;

endpackage

// File: rtl/mac_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// in: pending, last, en; out: grant index, valid.
module rr_arbiter #(
  parameter int N_CH = 2,
  parameter int CH_W = 1
) (
  input  logic [N_CH-1:0] pending,
  input  logic [CH_W-1:0] last,
  input  logic            en,
  output logic [CH_W-1:0] grant,
  output logic            valid
);

  logic [CH_W-1:0] idx;

  // Walk from lowest priority (last) to highest
  // (last+1); the final hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = CH_W'((int'(last) + k) % N_CH);
      if (en && pending[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_sched.sv
// mac_sched: shares one MAC filter datapath among
// N_CH channels; req/clr_ovr in, strobes/ch/done out.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int N_CH = N_CH_DEF,
  parameter int CH_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            clr_ovr,
  output logic [CH_W-1:0] ch,
  output logic            leer_u,
  output logic            rst_acum,
  output logic            acum_en,
  output logic [3:0]      sel,
  output logic            leer_y,
  output logic            desp,
  output logic [N_CH-1:0] done,
  output logic            busy,
  output logic [N_CH-1:0] overrun
);

  state_t          state, nxt;
  logic [CH_W-1:0] last_q, nxt_last, nxt_ch;
  logic [CH_W-1:0] gnt;
  logic            gnt_v;
  logic [CNT_W-1:0] cnt_q, nxt_cnt;
  logic [N_CH-1:0] pend_q, clr_pend, nxt_done;

  rr_arbiter #(
    .N_CH(N_CH),
    .CH_W(CH_W)
  ) u_arb (
    .pending(pend_q),
    .last   (last_q),
    .en     (state == IDLE),
    .grant  (gnt),
    .valid  (gnt_v)
  );

  assign sel = cnt_q[3:0];

  always_comb begin
    nxt      = state;
    nxt_ch   = ch;
    nxt_last = last_q;
    nxt_cnt  = cnt_q;
    clr_pend = '0;
    nxt_done = '0;
    unique case (state)
      IDLE: begin
        if (gnt_v) begin
          nxt           = LOAD;
          nxt_ch        = gnt;
          nxt_last      = gnt;
          clr_pend[gnt] = 1'b1;
        end
      end
      LOAD: begin
        nxt     = CLR;
        nxt_cnt = '0;
      end
      CLR:  nxt = MAC;
      MAC: begin
        if (cnt_q == CNT_W'(TAPS - 1))
          nxt = STORE;
        else
          nxt_cnt = cnt_q + CNT_W'(1);
      end
      STORE: nxt = SHIFT;
      SHIFT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (nxt == SHIFT)
      nxt_done[nxt_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ch       <= '0;
      last_q   <= CH_W'(N_CH - 1);
      cnt_q    <= '0;
      pend_q   <= '0;
      overrun  <= '0;
      leer_u   <= 1'b0;
      rst_acum <= 1'b0;
      acum_en  <= 1'b0;
      leer_y   <= 1'b0;
      desp     <= 1'b0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt;
      ch       <= nxt_ch;
      last_q   <= nxt_last;
      cnt_q    <= nxt_cnt;
      // A new request outranks the grant's clear.
      pend_q   <= (pend_q & ~clr_pend) | req;
      overrun  <= (clr_ovr ? '0 : overrun)
                | (req & pend_q & ~clr_pend);
      leer_u   <= (nxt == LOAD);
      rst_acum <= (nxt == CLR);
      acum_en  <= (nxt == MAC);
      leer_y   <= (nxt == STORE);
      desp     <= (nxt == SHIFT);
      done     <= nxt_done;
      busy     <= (nxt != IDLE);
    end
  end

endmodule
